// File: rtl/decoder_ctrl_if.sv
// Handshake and control bundle between the min-sum decoder controller and its datapath/host.
// The master modport is the controller side; the slave modport is the datapath/host side.
interface decoder_ctrl_if #(
  parameter int unsigned ITER_W = 3
) ();
  logic              in_valid;
  logic              in_ready;
  logic              load_en;
  logic              clr_msg;
  logic              layer_start;
  logic              layer_done;
  logic              msg_latch;
  logic              syndrome_ok;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              err;

  modport master (
    input  in_valid, layer_done, syndrome_ok, out_ready,
    output in_ready, load_en, clr_msg, layer_start, msg_latch, out_valid, iter_cnt, busy, err
  );

  modport slave (
    output in_valid, layer_done, syndrome_ok, out_ready,
    input  in_ready, load_en, clr_msg, layer_start, msg_latch, out_valid, iter_cnt, busy, err
  );
endinterface

// File: rtl/decoder_ctrl.sv
// Iteration controller for a layered min-sum decoder: load, N_ITER layer passes with timeout, output.
// Define DECODER_CTRL_EARLY_TERM_EN to stop as soon as a layer pass reports syndrome_ok.
module decoder_ctrl #(
  parameter int unsigned N_ITER  = 5,
  parameter int unsigned ITER_W  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  decoder_ctrl_if.master bus
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [ITER_W-1:0] IterLast = ITER_W'(N_ITER - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StOut} state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              early_term;

`ifdef DECODER_CTRL_EARLY_TERM_EN
  assign early_term = bus.syndrome_ok;
`else
  logic unused_syndrome;
  assign early_term      = 1'b0;
  assign unused_syndrome = bus.syndrome_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StLoad;
      end
      StLoad: begin
        iter_d  = '0;
        err_d   = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving on the final timeout cycle still wins over the timeout.
        if (bus.layer_done) begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = ((iter_q == IterLast) || early_term) ? StOut : StRun;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic in_ready, load_en, clr_msg, layer_start, msg_latch, out_valid, busy;

  always_comb begin
    in_ready    = 1'b0;
    load_en     = 1'b0;
    clr_msg     = 1'b0;
    layer_start = 1'b0;
    msg_latch   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StLoad: begin
        load_en = 1'b1;
        clr_msg = 1'b1;
      end
      StRun:   layer_start = 1'b1;
      StWait:  msg_latch   = bus.layer_done;
      StOut:   out_valid   = 1'b1;
      default: busy        = 1'b0;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.load_en     = load_en;
  assign bus.clr_msg     = clr_msg;
  assign bus.layer_start = layer_start;
  assign bus.msg_latch   = msg_latch;
  assign bus.out_valid   = out_valid;
  assign bus.busy        = busy;
  assign bus.iter_cnt    = iter_q;
  assign bus.err         = err_q;

endmodule
